// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - final pipeline stage driving the register-file write port
//
// Purpose:
//   Accepts one retiring instruction per handshake. Selects the write-back source
//   (ALU, load data, PC+4, CSR). Loads wait for the data-memory response, which is
//   then aligned and extended by func3. Upstream is stalled while a load is outstanding.
//
// Ports:
//   clk, reset (async active-low)
//   in_valid / in_ready                : instruction handshake
//   rd, reg_wr_in, wb_sel, func3       : instruction control
//   alu_result, pc_plus4, csr_rdata    : result sources (alu_result is the load byte address)
//   mem_rvalid, mem_rdata              : data-memory load response
//   reg_wr, address_wr, wb_out         : registered register-file write port
//   stall, load_err                    : load outstanding / load timeout pulse
//
// Optional feature (macro WB_FWD_EN):
//   rs1_addr, rs2_addr, rf_rdata1, rf_rdata2 in; fwd_rdata1, fwd_rdata2 out.
//   Combinational bypass of the current write into the decode read data.
module writeback_unit #(
  parameter int WIDTH        = 32,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rd,
  input  logic             reg_wr_in,
  input  logic [1:0]       wb_sel,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] csr_rdata,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             reg_wr,
  output logic [4:0]       address_wr,
  output logic [WIDTH-1:0] wb_out,
  output logic             stall,
  output logic             load_err
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [WIDTH-1:0] rf_rdata1,
  input  logic [WIDTH-1:0] rf_rdata2,
  output logic [WIDTH-1:0] fwd_rdata1,
  output logic [WIDTH-1:0] fwd_rdata2
`endif
);

  localparam int CW = (LOAD_TIMEOUT < 1) ? 1 : $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(LOAD_TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, cnt_d;
  logic            capture;

  // Pending load context, latched at accept time.
  logic [4:0]      ld_rd_q;
  logic            ld_wr_q;
  logic [2:0]      ld_func3_q;
  logic [1:0]      ld_off_q;

  logic            wr_d, err_d;
  logic [4:0]      addr_d;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] src_data;
  logic [WIDTH-1:0] load_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign in_ready = (state == IDLE);
  assign stall    = (state == WAIT_MEM);

  always_comb begin
    src_data = alu_result;
    case (wb_sel)
      2'b10:   src_data = pc_plus4;
      2'b11:   src_data = csr_rdata;
      default: src_data = alu_result;
    endcase
  end

  // Halfword selection uses only off[1]; misaligned halves are not split.
  always_comb begin
    ld_byte   = mem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half   = mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
    load_data = mem_rdata;
    case (ld_func3_q)
      3'b000:  load_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, ld_byte};
      3'b001:  load_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state and next write-port values. address_wr/wb_out default to their
  // current values so they hold whenever no write is committed.
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    capture    = 1'b0;
    wr_d       = 1'b0;
    err_d      = 1'b0;
    addr_d     = address_wr;
    data_d     = wb_out;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          if (wb_sel == 2'b01) begin
            capture    = 1'b1;
            next_state = WAIT_MEM;
          end else begin
            wr_d = reg_wr_in && (rd != 5'd0);
            if (wr_d) begin
              addr_d = rd;
              data_d = src_data;
            end
          end
        end
      end
      WAIT_MEM: begin
        // A response arriving on the timeout cycle still completes the load.
        if (mem_rvalid) begin
          next_state = IDLE;
          cnt_d      = '0;
          wr_d       = ld_wr_q;
          if (ld_wr_q) begin
            addr_d = ld_rd_q;
            data_d = load_data;
          end
        end else if (cnt == TO_MAX) begin
          next_state = IDLE;
          cnt_d      = '0;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_rd_q    <= '0;
      ld_wr_q    <= 1'b0;
      ld_func3_q <= '0;
      ld_off_q   <= '0;
    end else if (capture) begin
      ld_rd_q    <= rd;
      ld_wr_q    <= reg_wr_in && (rd != 5'd0);
      ld_func3_q <= func3;
      ld_off_q   <= alu_result[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_wr     <= 1'b0;
      address_wr <= '0;
      wb_out     <= '0;
      load_err   <= 1'b0;
    end else begin
      reg_wr     <= wr_d;
      address_wr <= addr_d;
      wb_out     <= data_d;
      load_err   <= err_d;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_rdata1 = (reg_wr && (address_wr == rs1_addr) && (rs1_addr != 5'd0)) ? wb_out : rf_rdata1;
  assign fwd_rdata2 = (reg_wr && (address_wr == rs2_addr) && (rs2_addr != 5'd0)) ? wb_out : rf_rdata2;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rd;
  logic        reg_wr_in;
  logic [1:0]  wb_sel;
  logic [2:0]  func3;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [31:0] csr_rdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_wr;
  logic [4:0]  address_wr;
  logic [31:0] wb_out;
  logic        stall;
  logic        load_err;
`ifdef WB_FWD_EN
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] fwd_rdata1;
  logic [31:0] fwd_rdata2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_unit #(.WIDTH(32), .LOAD_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd(rd), .reg_wr_in(reg_wr_in), .wb_sel(wb_sel), .func3(func3),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_wr(reg_wr), .address_wr(address_wr), .wb_out(wb_out),
    .stall(stall), .load_err(load_err)
`ifdef WB_FWD_EN
    ,
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a load, wait so that mem_rvalid arrives in the delay-th WAIT_MEM cycle.
  task automatic do_load(input logic [4:0] r, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int delay, input logic [31:0] exp,
                         input string tag);
    in_valid = 1'b1; wb_sel = 2'b01; rd = r; reg_wr_in = 1'b1; func3 = f3; alu_result = addr;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < delay; i++) step();
    check({tag, "_stall"}, {31'd0, stall}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = data;
    step();
    mem_rvalid = 1'b0;
    check({tag, "_wr"}, {31'd0, reg_wr}, 32'd1);
    check({tag, "_data"}, wb_out, exp);
    check({tag, "_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; rd = '0; reg_wr_in = 1'b0; wb_sel = '0; func3 = '0;
    alu_result = '0; pc_plus4 = '0; csr_rdata = '0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef WB_FWD_EN
    rs1_addr = 5'd5; rs2_addr = 5'd0; rf_rdata1 = 32'hDEAD_0001; rf_rdata2 = 32'hDEAD_0002;
`endif
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    check("rst_addr", {27'd0, address_wr}, 32'd0);
    check("rst_wb_out", wb_out, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    step();
    reset = 1'b1;
    step();

    // ALU write, latency 1, single-cycle reg_wr
    in_valid = 1'b1; wb_sel = 2'b00; rd = 5'd5; reg_wr_in = 1'b1; alu_result = 32'h0000_1234;
    step();
    in_valid = 1'b0;
    check("alu_wr", {31'd0, reg_wr}, 32'd1);
    check("alu_addr", {27'd0, address_wr}, 32'd5);
    check("alu_data", wb_out, 32'h0000_1234);
`ifdef WB_FWD_EN
    check("fwd_hit", fwd_rdata1, 32'h0000_1234);
    check("fwd_rs2_zero", fwd_rdata2, 32'hDEAD_0002);
`endif
    step();
    check("alu_wr_drop", {31'd0, reg_wr}, 32'd0);
    check("alu_hold", wb_out, 32'h0000_1234);
`ifdef WB_FWD_EN
    check("fwd_miss", fwd_rdata1, 32'hDEAD_0001);
`endif

    // Back-to-back ALU / PC+4 / CSR
    in_valid = 1'b1; wb_sel = 2'b00; rd = 5'd6; alu_result = 32'h0000_000A;
    pc_plus4 = 32'h0000_0104; csr_rdata = 32'h0000_CAFE;
    step();
    check("b2b0_wr", {31'd0, reg_wr}, 32'd1);
    check("b2b0_data", wb_out, 32'h0000_000A);
    wb_sel = 2'b10; rd = 5'd7;
    step();
    check("b2b1_wr", {31'd0, reg_wr}, 32'd1);
    check("b2b1_addr", {27'd0, address_wr}, 32'd7);
    check("b2b1_data", wb_out, 32'h0000_0104);
    wb_sel = 2'b11; rd = 5'd8;
    step();
    check("b2b2_wr", {31'd0, reg_wr}, 32'd1);
    check("b2b2_data", wb_out, 32'h0000_CAFE);

    // rd==0 and reg_wr_in==0 consume the slot without writing
    wb_sel = 2'b10; rd = 5'd0; reg_wr_in = 1'b1;
    step();
    check("rd0_wr", {31'd0, reg_wr}, 32'd0);
    check("rd0_ready", {31'd0, in_ready}, 32'd1);
    check("rd0_hold", wb_out, 32'h0000_CAFE);
    wb_sel = 2'b00; rd = 5'd9; reg_wr_in = 1'b0; alu_result = 32'h0000_0055;
    step();
    check("nowr_wr", {31'd0, reg_wr}, 32'd0);
    check("nowr_addr_hold", {27'd0, address_wr}, 32'd8);
    reg_wr_in = 1'b1;
    step();
    in_valid = 1'b0;
    check("after_nowr_wr", {31'd0, reg_wr}, 32'd1);
    check("after_nowr_data", wb_out, 32'h0000_0055);
    step();

    // LB, response in third WAIT_MEM cycle
    in_valid = 1'b1; wb_sel = 2'b01; rd = 5'd10; reg_wr_in = 1'b1; func3 = 3'b000;
    alu_result = 32'h0000_1003;
    step();
    in_valid = 1'b0;
    check("lb_stall1", {31'd0, stall}, 32'd1);
    check("lb_ready1", {31'd0, in_ready}, 32'd0);
    step();
    check("lb_stall2", {31'd0, stall}, 32'd1);
    step();
    check("lb_stall3", {31'd0, stall}, 32'd1);
    check("lb_ready3", {31'd0, in_ready}, 32'd0);
    check("lb_nowr", {31'd0, reg_wr}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    step();
    mem_rvalid = 1'b0;
    check("lb_wr", {31'd0, reg_wr}, 32'd1);
    check("lb_addr", {27'd0, address_wr}, 32'd10);
    check("lb_data", wb_out, 32'hFFFF_FF80);
    check("lb_ready_after", {31'd0, in_ready}, 32'd1);
    step();
    check("lb_wr_drop", {31'd0, reg_wr}, 32'd0);

    // Alignment variants
    do_load(5'd11, 3'b101, 32'h0000_2002, 32'hBEEF_1234, 1, 32'h0000_BEEF, "lhu_off2");
    do_load(5'd12, 3'b001, 32'h0000_2002, 32'hBEEF_1234, 2, 32'hFFFF_BEEF, "lh_off2");
    do_load(5'd13, 3'b001, 32'h0000_2001, 32'hBEEF_8001, 1, 32'hFFFF_8001, "lh_off1");
    do_load(5'd14, 3'b100, 32'h0000_2001, 32'h1234_5678, 1, 32'h0000_0056, "lbu_off1");
    do_load(5'd15, 3'b000, 32'h0000_2000, 32'h1234_5680, 1, 32'hFFFF_FF80, "lb_off0");
    do_load(5'd16, 3'b010, 32'h0000_2000, 32'h8765_4321, 1, 32'h8765_4321, "lw");
    do_load(5'd17, 3'b110, 32'h0000_2003, 32'hA5A5_0F0F, 1, 32'hA5A5_0F0F, "f3_other");
    // response on the timeout cycle wins
    do_load(5'd18, 3'b010, 32'h0000_2000, 32'h0BAD_F00D, 16, 32'h0BAD_F00D, "to_edge");
    check("to_edge_addr", {27'd0, address_wr}, 32'd18);
    step();

    // Timeout: no response
    in_valid = 1'b1; wb_sel = 2'b01; rd = 5'd19; reg_wr_in = 1'b1; func3 = 3'b010;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 16; i++) step();
    check("to_stall15", {31'd0, stall}, 32'd1);
    check("to_err_early", {31'd0, load_err}, 32'd0);
    step();
    check("to_err", {31'd0, load_err}, 32'd1);
    check("to_nowr", {31'd0, reg_wr}, 32'd0);
    check("to_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("to_err_pulse", {31'd0, load_err}, 32'd0);

    // Reset during WAIT_MEM, then stale response
    in_valid = 1'b1; wb_sel = 2'b01; rd = 5'd20;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    #2;
    check("mr_ready", {31'd0, in_ready}, 32'd1);
    check("mr_stall", {31'd0, stall}, 32'd0);
    check("mr_wb_out", wb_out, 32'd0);
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    check("mr_nowr", {31'd0, reg_wr}, 32'd0);
    check("mr_idle", {31'd0, in_ready}, 32'd1);
    step();
    check("mr_nowr2", {31'd0, reg_wr}, 32'd0);
    check("mr_addr", {27'd0, address_wr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
